// File: rtl/rf_pkg.sv
// Shared widths and queue entry type for the register-file write arbiter.
package rf_pkg;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic [REG_W-1:0]  rnum;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the arbiter's requester, write-port and busy-query signals.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [REG_W-1:0]  a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [REG_W-1:0]  b_reg;
    logic [DATA_W-1:0] b_data;
    logic              WriteReg;
    logic [REG_W-1:0]  DstReg;
    logic [DATA_W-1:0] DstData;
    logic [REG_W-1:0]  SrcReg1;
    logic [REG_W-1:0]  SrcReg2;
    logic              busy1;
    logic              busy2;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, SrcReg1, SrcReg2,
        input  a_ready, b_ready, WriteReg, DstReg, DstData, busy1, busy2
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, SrcReg1, SrcReg2,
        output a_ready, b_ready, WriteReg, DstReg, DstData, busy1, busy2
    );
endinterface

// File: rtl/rf_wq.sv
// Per-requester write queue: circular FIFO with per-entry register-match outputs.
module rf_wq
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wq_entry_t        entry_i,
    input  logic             pop_i,
    output wq_entry_t        head_o,
    output logic             empty_o,
    output logic             full_o,
    input  logic [REG_W-1:0] query1_i,
    input  logic [REG_W-1:0] query2_i,
    output logic             match1_o,
    output logic             match2_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // Only the 'count_q' slots starting at the read pointer hold live entries.
    always_comb begin
        match1_o = 1'b0;
        match2_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (mem_q[rd_ptr_q + PTR_W'(i)].rnum == query1_i) match1_o = 1'b1;
                if (mem_q[rd_ptr_q + PTR_W'(i)].rnum == query2_i) match2_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Merges ALU (A) and memory (B) writebacks onto one register-file write port.
// RFARB_ROUND_ROBIN_EN selects round-robin contention arbitration; default is A-priority.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              WriteReg,
    output logic [REG_W-1:0]  DstReg,
    output logic [DATA_W-1:0] DstData,
    input  logic [REG_W-1:0]  SrcReg1,
    input  logic [REG_W-1:0]  SrcReg2,
    output logic              busy1,
    output logic              busy2
);
    logic              a_full, a_empty, b_full, b_empty;
    logic              a_push, b_push, a_pop, b_pop, grant_a;
    logic              a_m1, a_m2, b_m1, b_m2;
    wq_entry_t         a_in, b_in, a_head, b_head, pop_entry;
    logic              write_q, write_d;
    logic [REG_W-1:0]  dst_reg_q, dst_reg_d;
    logic [DATA_W-1:0] dst_data_q, dst_data_d;

    assign a_ready = !a_full;
    assign b_ready = !b_full;
    // Writes to r0 are acknowledged but dropped before they reach a queue.
    assign a_push  = a_valid && a_ready && (a_reg != '0) && !rst;
    assign b_push  = b_valid && b_ready && (b_reg != '0) && !rst;
    assign a_in    = '{rnum: a_reg, data: a_data};
    assign b_in    = '{rnum: b_reg, data: b_data};

    rf_wq #(.DEPTH(DEPTH)) u_wq_a (
        .clk(clk), .rst(rst), .push_i(a_push), .entry_i(a_in), .pop_i(a_pop),
        .head_o(a_head), .empty_o(a_empty), .full_o(a_full),
        .query1_i(SrcReg1), .query2_i(SrcReg2), .match1_o(a_m1), .match2_o(a_m2)
    );

    rf_wq #(.DEPTH(DEPTH)) u_wq_b (
        .clk(clk), .rst(rst), .push_i(b_push), .entry_i(b_in), .pop_i(b_pop),
        .head_o(b_head), .empty_o(b_empty), .full_o(b_full),
        .query1_i(SrcReg1), .query2_i(SrcReg2), .match1_o(b_m1), .match2_o(b_m2)
    );

`ifdef RFARB_ROUND_ROBIN_EN
    grant_e last_grant_q, last_grant_d;
    logic   contended;

    assign contended = !a_empty && !b_empty;
    assign grant_a   = !a_empty && (b_empty || last_grant_q == GRANT_B);

    always_comb begin
        last_grant_d = last_grant_q;
        if (contended) last_grant_d = grant_a ? GRANT_A : GRANT_B;
    end

    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= GRANT_B;
        else     last_grant_q <= last_grant_d;
    end
`else
    assign grant_a = !a_empty;
`endif

    assign a_pop     = grant_a;
    assign b_pop     = !b_empty && !grant_a;
    assign pop_entry = a_pop ? a_head : b_head;

    always_comb begin
        write_d    = a_pop || b_pop;
        dst_reg_d  = dst_reg_q;
        dst_data_d = dst_data_q;
        if (write_d) begin
            dst_reg_d  = pop_entry.rnum;
            dst_data_d = pop_entry.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q    <= 1'b0;
            dst_reg_q  <= '0;
            dst_data_q <= '0;
        end else begin
            write_q    <= write_d;
            dst_reg_q  <= dst_reg_d;
            dst_data_q <= dst_data_d;
        end
    end

    assign WriteReg = write_q;
    assign DstReg   = dst_reg_q;
    assign DstData  = dst_data_q;

    assign busy1 = (SrcReg1 != '0) && (a_m1 || b_m1 || (write_q && dst_reg_q == SrcReg1));
    assign busy2 = (SrcReg2 != '0) && (a_m2 || b_m2 || (write_q && dst_reg_q == SrcReg2));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-level reference model predicts
// ready, busy and the write-port stream; predicted writes are queued and popped.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(bus.a_valid), .a_ready(bus.a_ready), .a_reg(bus.a_reg), .a_data(bus.a_data),
        .b_valid(bus.b_valid), .b_ready(bus.b_ready), .b_reg(bus.b_reg), .b_data(bus.b_data),
        .WriteReg(bus.WriteReg), .DstReg(bus.DstReg), .DstData(bus.DstData),
        .SrcReg1(bus.SrcReg1), .SrcReg2(bus.SrcReg2), .busy1(bus.busy1), .busy2(bus.busy2)
    );

    always #5 clk = ~clk;

    // Reference model state
    wq_entry_t         qa[$];
    wq_entry_t         qb[$];
    wq_entry_t         exp_wr[$];
    logic              cur_wr = 1'b0;
    logic [REG_W-1:0]  last_r = '0;
    logic [DATA_W-1:0] last_d = '0;
`ifdef RFARB_ROUND_ROBIN_EN
    logic              lg_b = 1'b1;
`endif
    logic              acc_a, acc_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic busy_model(input logic [REG_W-1:0] s);
        if (s == '0) return 1'b0;
        foreach (qa[i]) if (qa[i].rnum == s) return 1'b1;
        foreach (qb[i]) if (qb[i].rnum == s) return 1'b1;
        return cur_wr && (last_r == s);
    endfunction

    task automatic step(input logic r,
                        input logic av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [REG_W-1:0] br, input logic [DATA_W-1:0] bd,
                        input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                        output logic a_acc, output logic b_acc);
        wq_entry_t e;
        logic a_rdy, b_rdy, a_ne, b_ne, ga;
        @(negedge clk);
        if (exp_wr.size() != 0) begin
            e      = exp_wr.pop_front();
            cur_wr = 1'b1;
            last_r = e.rnum;
            last_d = e.data;
        end else begin
            cur_wr = 1'b0;
        end
        a_rdy = (qa.size() < DEPTH);
        b_rdy = (qb.size() < DEPTH);
        check("WriteReg", 32'(bus.WriteReg), 32'(cur_wr));
        check("DstReg",   32'(bus.DstReg),   32'(last_r));
        check("DstData",  32'(bus.DstData),  32'(last_d));
        check("a_ready",  32'(bus.a_ready),  32'(a_rdy));
        check("b_ready",  32'(bus.b_ready),  32'(b_rdy));

        rst         = r;
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        bus.SrcReg1 = s1; bus.SrcReg2 = s2;
        #1;
        check("busy1", 32'(bus.busy1), 32'(busy_model(s1)));
        check("busy2", 32'(bus.busy2), 32'(busy_model(s2)));

        a_acc = av && a_rdy && !r;
        b_acc = bv && b_rdy && !r;
        if (r) begin
            qa.delete(); qb.delete(); exp_wr.delete();
            last_r = '0; last_d = '0;
`ifdef RFARB_ROUND_ROBIN_EN
            lg_b = 1'b1;
`endif
        end else begin
            a_ne = (qa.size() != 0);
            b_ne = (qb.size() != 0);
`ifdef RFARB_ROUND_ROBIN_EN
            ga = a_ne && (!b_ne || lg_b);
            if (a_ne && b_ne) lg_b = !ga;
`else
            ga = a_ne;
`endif
            if (ga)        exp_wr.push_back(qa.pop_front());
            else if (b_ne) exp_wr.push_back(qb.pop_front());
            if (a_acc && ar != '0) begin e.rnum = ar; e.data = ad; qa.push_back(e); end
            if (b_acc && br != '0) begin e.rnum = br; e.data = bd; qb.push_back(e); end
        end
    endtask

    task automatic idle(input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, s1, s2, acc_a, acc_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [REG_W-1:0]  wr_r [4];
        logic [DATA_W-1:0] wr_d [4];
        int unsigned       ia, ib;

        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
        bus.SrcReg1 = '0;   bus.SrcReg2 = '0;

        // Reset and quiescent state
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 4'd3, 4'd0, acc_a, acc_b);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 4'd3, 4'd0, acc_a, acc_b);
        idle(4'd3, 4'd5);

        // Single A write, busy tracked through queue and output register
        step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, '0, '0, 4'd3, 4'd3, acc_a, acc_b);
        check("a_accept", 32'(acc_a), 32'd1);
        repeat (4) idle(4'd3, 4'd4);

        // Two contentions: order depends on arbitration mode
        step(1'b0, 1'b1, 4'd5, 16'h0001, 1'b1, 4'd6, 16'h0002, 4'd5, 4'd6, acc_a, acc_b);
        repeat (3) idle(4'd5, 4'd6);
        step(1'b0, 1'b1, 4'd7, 16'h0003, 1'b1, 4'd8, 16'h0004, 4'd7, 4'd8, acc_a, acc_b);
        repeat (3) idle(4'd7, 4'd8);

        // Same destination from both requesters
        step(1'b0, 1'b1, 4'd9, 16'hAAAA, 1'b1, 4'd9, 16'hBBBB, 4'd9, 4'd1, acc_a, acc_b);
        repeat (3) idle(4'd9, 4'd1);

        // A-only stream held valid until each write is accepted
        wr_r = '{4'd1, 4'd2, 4'd3, 4'd4};
        wr_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        ia = 0;
        for (int c = 0; c < 40 && ia < 4; c++) begin
            step(1'b0, 1'b1, wr_r[ia], wr_d[ia], 1'b0, '0, '0, wr_r[ia], 4'd2, acc_a, acc_b);
            if (acc_a) ia++;
        end
        check("a_stream_done", ia, 4);
        repeat (4) idle(4'd4, 4'd1);

        // Both streams held valid: one pop per cycle forces backpressure
        ia = 0; ib = 0;
        for (int c = 0; c < 60 && (ia < 4 || ib < 4); c++) begin
            step(1'b0, ia < 4, 4'(ia + 10), 16'(16'hA000 + ia),
                       ib < 4, 4'(ib + 2),  16'(16'hB000 + ib), 4'd11, 4'd3, acc_a, acc_b);
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        check("ab_stream_done", ia + ib, 8);
        repeat (8) idle(4'd12, 4'd4);

        // Writes to r0 are accepted and dropped
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, acc_a, acc_b);
        check("r0_accept", 32'(acc_b), 32'd1);
        repeat (3) idle(4'd0, 4'd0);

        // Fill both queues, then flush with a one-cycle reset while inputs stay active
        for (int c = 0; c < 4; c++)
            step(1'b0, 1'b1, 4'(c + 1), 16'(16'hC000 + c), 1'b1, 4'(c + 8), 16'(16'hD000 + c),
                 4'd1, 4'd8, acc_a, acc_b);
        step(1'b1, 1'b1, 4'd13, 16'hEEEE, 1'b1, 4'd14, 16'hEEEE, 4'd13, 4'd14, acc_a, acc_b);
        repeat (4) idle(4'd2, 4'd9);

        // Random traffic with register collisions
        for (int c = 0; c < 300; c++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)),
                 16'($urandom), ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)), 16'($urandom),
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), acc_a, acc_b);
        repeat (8) idle(4'd0, 4'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
